// File: rtl/pin_vault_pkg.sv
// ============================================================================
// pin_vault_pkg : shared state encoding and width helpers for the PIN vault
// Rev 1.0
// ============================================================================
`default_nettype none

package pin_vault_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_UNLOCKED = 2'd1,
    ST_CONFIRM  = 2'd2,
    ST_LOCKED   = 2'd3
  } state_e;

  // Width helpers; a zero-width result is promoted to one bit.
  function automatic int clog2_min1(input int v);
    return (v <= 1) ? 1 : $clog2(v);
  endfunction

  function automatic int pin_w(input int digits, input int digit_w);
    return digits * digit_w;
  endfunction

  function automatic int cnt_w(input int digits);
    return clog2_min1(digits + 1);
  endfunction

  function automatic int fail_w(input int max_fail);
    return clog2_min1(max_fail + 1);
  endfunction

  function automatic int tmr_w(input int lock_cycles);
    return clog2_min1(lock_cycles);
  endfunction

  // Widths for the default configuration (4 digits of 4 bits, 3 fails, 1000 cycles).
  localparam int PIN_W  = pin_w(4, 4);
  localparam int CNT_W  = cnt_w(4);
  localparam int FAIL_W = fail_w(3);
  localparam int TMR_W  = tmr_w(1000);

endpackage

`default_nettype wire

// File: rtl/pin_entry_buf.sv
// ============================================================================
// pin_entry_buf : digit-serial shift buffer with saturating count and clear
// Rev 1.0
// ============================================================================
`default_nettype none

module pin_entry_buf
  import pin_vault_pkg::*;
#(
  parameter int DIGITS  = 4,
  parameter int DIGIT_W = 4
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_shift,
  input  logic [DIGIT_W-1:0]            i_digit,
  input  logic                          i_clear,
  output logic [pin_w(DIGITS,DIGIT_W)-1:0] o_entry,
  output logic [cnt_w(DIGITS)-1:0]      o_cnt,
  output logic                          o_full
);

  localparam int c_PIN_W = pin_w(DIGITS, DIGIT_W);
  localparam int c_CNT_W = cnt_w(DIGITS);
  localparam logic [c_CNT_W-1:0] c_FULL = c_CNT_W'(DIGITS);

  logic [c_PIN_W-1:0] r_entry;
  logic [c_CNT_W-1:0] r_cnt;
  logic [c_PIN_W-1:0] w_shifted;
  logic               w_full;
  logic               w_shift_en;

  // First digit keyed ends up in the most significant position.
  generate
    if (DIGITS == 1) begin : g_single
      assign w_shifted = i_digit;
    end else begin : g_multi
      assign w_shifted = {r_entry[c_PIN_W-DIGIT_W-1:0], i_digit};
    end
  endgenerate

  assign w_full     = (r_cnt == c_FULL);
  assign w_shift_en = i_shift && !w_full;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_entry <= '0;
      r_cnt   <= '0;
    end else if (i_clear) begin
      r_entry <= '0;
      r_cnt   <= '0;
    end else if (w_shift_en) begin
      r_entry <= w_shifted;
      r_cnt   <= r_cnt + c_CNT_W'(1);
    end
  end

  assign o_entry = r_entry;
  assign o_cnt   = r_cnt;
  assign o_full  = w_full;

endmodule

`default_nettype wire

// File: rtl/pin_vault.sv
// ============================================================================
// pin_vault : multi-digit PIN store with verify, lockout and confirmed change
// Rev 1.0
// ============================================================================
`default_nettype none

module pin_vault
  import pin_vault_pkg::*;
#(
  parameter int                              DIGITS      = 4,
  parameter int                              DIGIT_W     = 4,
  parameter int                              MAX_FAIL    = 3,
  parameter int                              LOCK_CYCLES = 1000,
  parameter logic [DIGITS*DIGIT_W-1:0]       RESET_PIN   = '0
) (
  input  logic                               i_clk,
  input  logic                               i_rst_n,
  input  logic                               i_digit_valid,
  input  logic [DIGIT_W-1:0]                 i_digit,
  input  logic                               i_clear,
  input  logic                               i_verify,
  input  logic                               i_change,
  input  logic                               i_relock,
  output logic [DIGITS*DIGIT_W-1:0]          o_stored_pin,
  output logic [cnt_w(DIGITS)-1:0]           o_entry_cnt,
  output logic                               o_match,
  output logic                               o_fail,
  output logic                               o_change_ok,
  output logic                               o_change_err,
  output logic                               o_unlocked,
  output logic                               o_confirm_pending,
  output logic                               o_locked
);

  localparam int c_PIN_W  = pin_w(DIGITS, DIGIT_W);
  localparam int c_FAIL_W = fail_w(MAX_FAIL);
  localparam int c_TMR_W  = tmr_w(LOCK_CYCLES);
  localparam logic [c_FAIL_W-1:0] c_FAIL_MAX = c_FAIL_W'(MAX_FAIL);
  localparam logic [c_TMR_W-1:0]  c_TMR_INIT = c_TMR_W'(LOCK_CYCLES - 1);

  state_e              r_state, w_state_nxt;
  logic [c_PIN_W-1:0]  r_pin, w_pin_nxt;
  logic [c_PIN_W-1:0]  r_cand, w_cand_nxt;
  logic [c_FAIL_W-1:0] r_fail, w_fail_nxt;
  logic [c_TMR_W-1:0]  r_tmr, w_tmr_nxt;
  logic                r_match, r_fail_p, r_ok, r_err;
  logic                w_match_nxt, w_fail_p_nxt, w_ok_nxt, w_err_nxt;

  logic [c_PIN_W-1:0]  w_entry;
  logic                w_full;
  logic                w_is_locked;
  logic                w_cmd_rel, w_cmd_chg, w_cmd_ver, w_accept;
  logic [c_FAIL_W-1:0] w_fail_inc;

  assign w_is_locked = (r_state == ST_LOCKED);

  // Relock needs no entry; the other commands need a full buffer and a legal state.
  assign w_cmd_rel = i_relock && !w_is_locked;
  assign w_cmd_chg = !w_cmd_rel && i_change && w_full &&
                     (r_state == ST_UNLOCKED || r_state == ST_CONFIRM);
  assign w_cmd_ver = !w_cmd_rel && !w_cmd_chg && i_verify && w_full &&
                     (r_state == ST_IDLE || r_state == ST_UNLOCKED);
  assign w_accept  = w_cmd_rel || w_cmd_chg || w_cmd_ver;
  assign w_fail_inc = r_fail + c_FAIL_W'(1);

  pin_entry_buf #(
    .DIGITS  (DIGITS),
    .DIGIT_W (DIGIT_W)
  ) u_entry (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_shift (i_digit_valid && !w_is_locked && !w_accept),
    .i_digit (i_digit),
    .i_clear ((i_clear && !w_is_locked) || w_accept),
    .o_entry (w_entry),
    .o_cnt   (o_entry_cnt),
    .o_full  (w_full)
  );

  always_comb begin
    w_state_nxt  = r_state;
    w_pin_nxt    = r_pin;
    w_cand_nxt   = r_cand;
    w_fail_nxt   = r_fail;
    w_tmr_nxt    = r_tmr;
    w_match_nxt  = 1'b0;
    w_fail_p_nxt = 1'b0;
    w_ok_nxt     = 1'b0;
    w_err_nxt    = 1'b0;
    case (r_state)
      ST_LOCKED: begin
        if (r_tmr == '0) begin
          w_state_nxt = ST_IDLE;
          w_fail_nxt  = '0;
        end else begin
          w_tmr_nxt = r_tmr - c_TMR_W'(1);
        end
      end
      default: begin
        if (w_cmd_rel) begin
          w_state_nxt = ST_IDLE;
          w_cand_nxt  = '0;
        end else if (w_cmd_chg) begin
          if (r_state == ST_UNLOCKED) begin
            w_cand_nxt  = w_entry;
            w_state_nxt = ST_CONFIRM;
          end else begin
            if (w_entry == r_cand) begin
              w_pin_nxt = r_cand;
              w_ok_nxt  = 1'b1;
            end else begin
              w_err_nxt = 1'b1;
            end
            w_cand_nxt  = '0;
            w_state_nxt = ST_UNLOCKED;
          end
        end else if (w_cmd_ver) begin
          if (w_entry == r_pin) begin
            w_match_nxt = 1'b1;
            w_fail_nxt  = '0;
            w_state_nxt = ST_UNLOCKED;
          end else begin
            w_fail_p_nxt = 1'b1;
            w_fail_nxt   = w_fail_inc;
            if (w_fail_inc == c_FAIL_MAX) begin
              w_state_nxt = ST_LOCKED;
              w_tmr_nxt   = c_TMR_INIT;
            end else begin
              w_state_nxt = ST_IDLE;
            end
          end
        end
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state  <= ST_IDLE;
      r_pin    <= RESET_PIN;
      r_cand   <= '0;
      r_fail   <= '0;
      r_tmr    <= '0;
      r_match  <= 1'b0;
      r_fail_p <= 1'b0;
      r_ok     <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_pin    <= w_pin_nxt;
      r_cand   <= w_cand_nxt;
      r_fail   <= w_fail_nxt;
      r_tmr    <= w_tmr_nxt;
      r_match  <= w_match_nxt;
      r_fail_p <= w_fail_p_nxt;
      r_ok     <= w_ok_nxt;
      r_err    <= w_err_nxt;
    end
  end

  assign o_stored_pin      = r_pin;
  assign o_match           = r_match;
  assign o_fail            = r_fail_p;
  assign o_change_ok       = r_ok;
  assign o_change_err      = r_err;
  assign o_unlocked        = (r_state == ST_UNLOCKED) || (r_state == ST_CONFIRM);
  assign o_confirm_pending = (r_state == ST_CONFIRM);
  assign o_locked          = w_is_locked;

endmodule

`default_nettype wire

// File: doc/pin_vault.md
Name: pin_vault

Overview:
- Parametrised successor to the single-nibble master-PIN store: holds a multi-digit PIN and accepts digit-serial keypad entry.
- Verifies entries against the stored PIN and enforces fail-count lockout.
- Supports a two-step confirmed PIN change.
- Sits between the keypad/debounce front end and the alarm control FSM.

Parameters:
- DIGITS, 4, number of PIN digits.
- DIGIT_W, 4, bits per digit.
- MAX_FAIL, 3, consecutive failed verifies before lockout (≥1).
- LOCK_CYCLES, 1000, lockout duration in i_clk cycles (≥1).
- RESET_PIN, 0, PIN value loaded at reset (DIGITS*DIGIT_W bits).

Ports:
- i_clk  in  1  system clock
- i_rst_n  in  1  synchronous active-low reset
- i_digit_valid  in  1  one-cycle strobe: i_digit is a new key
- i_digit  in  DIGIT_W  digit value
- i_clear  in  1  discard partial entry
- i_verify  in  1  command: compare entry with stored PIN
- i_change  in  1  command: propose/confirm new PIN (UNLOCKED/CONFIRM only)
- i_relock  in  1  command: leave UNLOCKED/CONFIRM, return to IDLE
- o_stored_pin  out  DIGITS*DIGIT_W  committed PIN
- o_entry_cnt  out  $clog2(DIGITS+1)  digits currently buffered
- o_match  out  1  one-cycle pulse: verify succeeded
- o_fail  out  1  one-cycle pulse: verify failed
- o_change_ok  out  1  one-cycle pulse: new PIN committed
- o_change_err  out  1  one-cycle pulse: confirmation mismatch
- o_unlocked  out  1  level: state is UNLOCKED or CONFIRM
- o_confirm_pending  out  1  level: state is CONFIRM
- o_locked  out  1  level: state is LOCKED

Behaviour:
- Reset (i_rst_n=0 at an edge):
  - o_stored_pin=RESET_PIN.
  - Entry buffer, candidate, fail counter and lock timer cleared.
  - State IDLE; all pulses and levels 0.
  - Reset mid-operation (including CONFIRM or LOCKED) behaves the same: the candidate is discarded.
- Entry buffer:
  - Each i_digit_valid shifts the digit in; the first digit entered is the most significant.
  - o_entry_cnt increments, saturating at DIGITS; digits beyond DIGITS are ignored.
  - i_clear empties the buffer and wins over a simultaneous i_digit_valid.
  - Digits are ignored in LOCKED.
- A command is accepted only when o_entry_cnt==DIGITS, except i_relock, which is always accepted outside LOCKED.
  - Commands with an incomplete entry are ignored: no pulse, buffer kept.
  - An accepted command empties the buffer.
  - Command priority: i_relock > i_change > i_verify; a digit strobe in the same cycle as an accepted command is dropped.
- Result pulses are registered and appear the cycle after the command.
- FSM states:
  - IDLE:
    - i_verify with match → o_match, fail counter=0, go to UNLOCKED.
    - i_verify with mismatch → o_fail, fail counter+1; if it reaches MAX_FAIL → LOCKED with timer=LOCK_CYCLES-1.
    - i_change is ignored.
  - UNLOCKED:
    - i_change → candidate=entry, go to CONFIRM.
    - i_verify → re-verify with the same rules as IDLE, but a mismatch returns to IDLE.
    - i_relock → IDLE.
  - CONFIRM:
    - i_change with entry==candidate → o_stored_pin=candidate, o_change_ok, go to UNLOCKED.
    - i_change with a mismatch → o_change_err, stored PIN unchanged, go to UNLOCKED.
    - i_verify is ignored.
    - i_relock → IDLE, candidate discarded.
  - LOCKED:
    - o_locked=1; all inputs except reset are ignored.
    - Timer decrements each cycle; at 0 → IDLE, fail counter=0.
    - Total lock time is exactly LOCK_CYCLES cycles.
- Fail counter:
  - Width $clog2(MAX_FAIL+1).
  - Cleared on match and on lock expiry; never wraps.
- o_stored_pin changes only on reset or o_change_ok.

Decomposition:
- Package pin_vault_pkg holds:
  - state enum (IDLE, UNLOCKED, CONFIRM, LOCKED);
  - derived width localparams (PIN_W=DIGITS*DIGIT_W, CNT_W, FAIL_W, TMR_W).
- One natural sub-module: pin_entry_buf, holding the shift buffer, count and clear logic.
- FSM, compare, candidate and timer live in the top.

Test Plan (DIGITS=4, DIGIT_W=4, MAX_FAIL=3, LOCK_CYCLES=8, RESET_PIN=16'h0000):
- Reset, key 0,0,0,0, i_verify → next cycle o_match=1 for 1 cycle, o_unlocked=1, o_entry_cnt=0.
- From UNLOCKED: key 1,2,3,4 + i_change → o_confirm_pending=1; key 1,2,3,4 + i_change → o_change_ok pulse, o_stored_pin=16'h1234, o_unlocked=1.
- From UNLOCKED with stored 16'h1234: propose 5,6,7,8, confirm 5,6,7,9 → o_change_err pulse, o_stored_pin stays 16'h1234, state UNLOCKED.
- IDLE: three verifies of 9,9,9,9 → three o_fail pulses and o_locked=1 after the third; digits keyed while locked leave o_entry_cnt=0; o_locked drops after exactly 8 cycles; then 0,0,0,0 verify → o_match.
- Key 1,2,3,4,5 → o_entry_cnt=4, buffer 16'h1234; i_clear with i_digit_valid in the same cycle → o_entry_cnt=0; i_verify with 2 digits → no pulse, o_entry_cnt=2.
- In CONFIRM (candidate 16'hABCD) assert i_rst_n=0 for one cycle → o_stored_pin=16'h0000, all levels 0, state IDLE.
